// File: rtl/passcode_checker_if.sv
// Switch-side / display-side bundle of the passcode lock front end.
interface passcode_checker_if;
    logic       i_Digit_Valid;
    logic [1:0] i_Digit;
    logic [2:0] o_Answer;
    logic [2:0] o_Digit_Count;
    logic       o_Unlock;
    logic       o_Locked;

    modport master (
        output i_Digit_Valid,
        output i_Digit,
        input  o_Answer,
        input  o_Digit_Count,
        input  o_Unlock,
        input  o_Locked
    );

    modport slave (
        input  i_Digit_Valid,
        input  i_Digit,
        output o_Answer,
        output o_Digit_Count,
        output o_Unlock,
        output o_Locked
    );
endinterface

// File: rtl/passcode_checker.sv
// Passcode lock front end: four-digit entry, compare, answer hold,
// entry timeout and lockout after repeated failures.
module passcode_checker #(
    parameter logic [7:0]  CODE           = 8'b00_01_10_11,
    parameter int unsigned HOLD_CYCLES    = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 125_000_000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCK_CYCLES    = 250_000_000
) (
    input logic               i_Clk,
    input logic               i_Rst,
    passcode_checker_if.slave bus
);

    localparam int unsigned MAX_HT =
        (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYC =
        (MAX_HT > LOCK_CYCLES) ? MAX_HT : LOCK_CYCLES;
    localparam int TW = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
    localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAILS);

    localparam logic [2:0] ANS_BLANK = 3'd0;
    localparam logic [2:0] ANS_OK    = 3'd1;
    localparam logic [2:0] ANS_NO    = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        SHOW_OK,
        SHOW_FAIL,
        LOCKOUT
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    fail_cnt;
    logic          match;

    function automatic logic [1:0] code_digit(input logic [1:0] idx);
        logic [1:0] d;
        unique case (idx)
            2'd0:    d = CODE[7:6];
            2'd1:    d = CODE[5:4];
            2'd2:    d = CODE[3:2];
            default: d = CODE[1:0];
        endcase
        return d;
    endfunction

    // Count is 0 in IDLE, so the same index serves the first digit too.
    logic digit_ok;
    logic match_nx;
    assign digit_ok = (bus.i_Digit == code_digit(bus.o_Digit_Count[1:0]));
    assign match_nx = match & digit_ok;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state             <= IDLE;
            timer             <= '0;
            fail_cnt          <= '0;
            match             <= 1'b1;
            bus.o_Answer      <= ANS_BLANK;
            bus.o_Digit_Count <= '0;
            bus.o_Unlock      <= 1'b0;
            bus.o_Locked      <= 1'b0;
        end else begin
            bus.o_Unlock <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_Digit_Valid) begin
                        state             <= ENTRY;
                        bus.o_Digit_Count <= 3'd1;
                        match             <= digit_ok;
                        timer             <= '0;
                    end
                end
                ENTRY: begin
                    if (bus.i_Digit_Valid) begin
                        bus.o_Digit_Count <= bus.o_Digit_Count + 3'd1;
                        match             <= match_nx;
                        timer             <= '0;
                        if (bus.o_Digit_Count == 3'd3) begin
                            if (match_nx) begin
                                state        <= SHOW_OK;
                                bus.o_Answer <= ANS_OK;
                                bus.o_Unlock <= 1'b1;
                                fail_cnt     <= '0;
                            end else begin
                                state        <= SHOW_FAIL;
                                bus.o_Answer <= ANS_NO;
                                if (fail_cnt < FAIL_MAX)
                                    fail_cnt <= fail_cnt + 3'd1;
                            end
                        end
                    end else if (timer == TO_LAST) begin
                        state             <= IDLE;
                        bus.o_Digit_Count <= '0;
                        timer             <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SHOW_OK: begin
                    if (timer == HOLD_LAST) begin
                        state             <= IDLE;
                        bus.o_Answer      <= ANS_BLANK;
                        bus.o_Digit_Count <= '0;
                        timer             <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SHOW_FAIL: begin
                    if (timer == HOLD_LAST) begin
                        timer             <= '0;
                        bus.o_Digit_Count <= '0;
                        if (fail_cnt >= FAIL_MAX) begin
                            state        <= LOCKOUT;
                            bus.o_Locked <= 1'b1;
                        end else begin
                            state        <= IDLE;
                            bus.o_Answer <= ANS_BLANK;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer == LOCK_LAST) begin
                        state        <= IDLE;
                        bus.o_Answer <= ANS_BLANK;
                        bus.o_Locked <= 1'b0;
                        fail_cnt     <= '0;
                        timer        <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_passcode_checker.sv
// Scoreboard bench: stimulus queues expected output events with their
// spacing in cycles; a negedge monitor pops one per observed output change.
module tb_passcode_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    passcode_checker_if bus ();

    passcode_checker #(
        .CODE           (8'b00_01_10_11),
        .HOLD_CYCLES    (8),
        .TIMEOUT_CYCLES (20),
        .MAX_FAILS      (3),
        .LOCK_CYCLES    (30)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] cnt;
        logic [2:0] ans;
        logic       unl;
        logic       lck;
    } snap_t;

    typedef struct {
        snap_t s;
        int    dt;
    } exp_t;

    exp_t  exp_q[$];
    int    n_vec  = 0;
    int    n_bad  = 0;
    int    cyc    = 0;
    int    last   = 0;
    bit    mon_en = 1'b0;
    snap_t prev   = '0;

    function automatic snap_t sample();
        snap_t s;
        s.cnt = bus.o_Digit_Count;
        s.ans = bus.o_Answer;
        s.unl = bus.o_Unlock;
        s.lck = bus.o_Locked;
        return s;
    endfunction

    // dt of 0 marks an event whose distance from the previous one is free.
    always @(negedge clk) begin
        snap_t cur;
        exp_t  e;
        int    dt;
        cyc++;
        if (mon_en) begin
            cur = sample();
            if (cur != prev) begin
                dt = cyc - last;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got cnt=%0d ans=%0d unl=%0d lck=%0d at cycle %0d",
                             cur.cnt, cur.ans, cur.unl, cur.lck, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e.s || (e.dt != 0 && dt != e.dt)) begin
                        n_bad++;
                        $display("FAIL event: got cnt=%0d ans=%0d unl=%0d lck=%0d dt=%0d, required cnt=%0d ans=%0d unl=%0d lck=%0d dt=%0d",
                                 cur.cnt, cur.ans, cur.unl, cur.lck, dt,
                                 e.s.cnt, e.s.ans, e.s.unl, e.s.lck, e.dt);
                    end
                end
                prev = cur;
                last = cyc;
            end
        end
    end

    task automatic push(input int c, input int a, input int u,
                        input int l, input int dt);
        exp_t e;
        e.s.cnt = 3'(c);
        e.s.ans = 3'(a);
        e.s.unl = 1'(u);
        e.s.lck = 1'(l);
        e.dt    = dt;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int d);
        bus.i_Digit_Valid = 1'b1;
        bus.i_Digit       = 2'(d);
        tick(1);
        bus.i_Digit_Valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic entry4(input int d0, input int d1, input int d2,
                          input int d3, input bit ok);
        push(1, 0, 0, 0, 0);
        push(2, 0, 0, 0, 1);
        push(3, 0, 0, 0, 1);
        if (ok) begin
            push(4, 1, 1, 0, 1);
            push(4, 1, 0, 0, 1);
        end else begin
            push(4, 2, 0, 0, 1);
        end
        pulse(d0);
        pulse(d1);
        pulse(d2);
        pulse(d3);
    endtask

    task automatic good();
        entry4(0, 1, 2, 3, 1'b1);
        push(0, 0, 0, 0, 7);
        tick(12);
    endtask

    task automatic bad();
        entry4(0, 1, 2, 0, 1'b0);
        push(0, 0, 0, 0, 8);
        tick(12);
    endtask

    initial begin
        snap_t r;
        bus.i_Digit_Valid = 1'b0;
        bus.i_Digit       = 2'd0;
        tick(3);
        r = sample();
        n_vec++;
        if (r != '0) begin
            n_bad++;
            $display("FAIL reset_state: got cnt=%0d ans=%0d unl=%0d lck=%0d, required all 0",
                     r.cnt, r.ans, r.unl, r.lck);
        end
        rst    = 1'b0;
        prev   = '0;
        last   = cyc;
        mon_en = 1'b1;
        tick(2);

        // accept, reject, fail counter cleared by success
        good();
        bad();
        bad();
        good();
        bad();
        bad();
        good();

        // three rejections then lockout; pulses inside lockout ignored
        bad();
        bad();
        entry4(3, 3, 3, 3, 1'b0);
        push(0, 2, 0, 1, 8);
        push(0, 0, 0, 0, 30);
        tick(10);
        pulse(0);
        pulse(1);
        tick(5);
        pulse(2);
        tick(25);
        good();

        // timeout after 20 idle cycles, then pulse exactly on cycle 20
        push(1, 0, 0, 0, 0);
        push(2, 0, 0, 0, 1);
        push(0, 0, 0, 0, 20);
        pulse(0);
        pulse(1);
        tick(25);
        push(1, 0, 0, 0, 0);
        push(2, 0, 0, 0, 1);
        push(3, 0, 0, 0, 20);
        push(4, 1, 1, 0, 1);
        push(4, 1, 0, 0, 1);
        push(0, 0, 0, 0, 7);
        pulse(0);
        pulse(1);
        tick(19);
        pulse(2);
        pulse(3);
        tick(12);

        // reset mid-entry
        push(1, 0, 0, 0, 0);
        push(2, 0, 0, 0, 1);
        push(0, 0, 0, 0, 1);
        pulse(0);
        pulse(1);
        do_reset();
        tick(3);

        // reset mid-hold of what would be the third failure
        bad();
        bad();
        entry4(1, 1, 1, 1, 1'b0);
        push(0, 0, 0, 0, 3);
        tick(2);
        do_reset();
        tick(3);

        // counter was cleared: two more failures stay out of lockout
        bad();
        bad();
        entry4(2, 2, 2, 2, 1'b0);
        push(0, 2, 0, 1, 8);
        push(0, 0, 0, 0, 6);
        tick(13);
        do_reset();
        tick(3);
        good();
        tick(5);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: got %0d left in queue, required 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
